// File: rtl/csr_issue_serializer.sv
// CSR issue serializer: buffers CSR instructions in a circular queue, resolves the
// rs1 operand (immediate / bypass / GRF) and dispatches one CSR at a time.
module csr_issue_serializer #(
  parameter int              INSTR_W    = 113,
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter int              DEP_W      = 4,
  parameter logic [DEP_W-1:0] BYPASS_TAG = {DEP_W{1'b1}},
  parameter int              REG_W      = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_flush,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [INSTR_W-1:0]       i_in_instr,
  input  logic                     i_in_imm_sel,
  input  logic [XLEN-1:0]          i_in_imm,
  input  logic [DEP_W-1:0]         i_in_dep,
  input  logic [REG_W-1:0]         i_in_rs1,
  output logic [REG_W-1:0]         o_rf_rs1,
  input  logic [XLEN-1:0]          i_rf_data,
  input  logic                     i_byp_valid,
  input  logic [XLEN-1:0]          i_byp_data,
  output logic                     o_ex_valid,
  input  logic                     i_ex_ready,
  output logic [INSTR_W-1:0]       o_ex_instr,
  output logic [XLEN-1:0]          o_ex_operand,
  input  logic                     i_wb_done,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_gray,
  output logic                     o_busy,
  output logic                     o_wb_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, OUT, WAIT_WB} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               imm_sel;
    logic [XLEN-1:0]    imm;
    logic [DEP_W-1:0]   dep;
    logic [REG_W-1:0]   rs1;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  state_t             state, state_nxt;
  logic               push, pop, op_ready;
  logic [XLEN-1:0]    head_operand;

  assign head       = mem[rd_ptr];
  assign o_rf_rs1   = head.rs1;
  assign o_in_ready = (count != CNT_W'(DEPTH));
  assign push       = i_in_valid && o_in_ready && !i_flush;
  assign o_count    = count;
  assign o_busy     = (state != IDLE);

  // NOTE: payload storage has no reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{instr: i_in_instr, imm_sel: i_in_imm_sel, imm: i_in_imm,
                               dep: i_in_dep, rs1: i_in_rs1};
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    head_operand = i_rf_data;
    op_ready     = 1'b1;
    if (head.imm_sel) begin
      head_operand = head.imm;
    end else if (head.dep == BYPASS_TAG) begin
      head_operand = i_byp_data;
      op_ready     = i_byp_valid;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 && op_ready && !i_flush) begin
          pop       = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT:     if (i_ex_ready) state_nxt = WAIT_WB;
      WAIT_WB: if (i_wb_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (i_flush)             count_nxt = '0;
    else if (push && !pop)   count_nxt = count + 1'b1;
    else if (pop && !push)   count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_count_gray <= '0;
      o_ex_valid   <= 1'b0;
      o_ex_instr   <= '0;
      o_ex_operand <= '0;
      o_wb_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      o_count_gray <= count_nxt ^ (count_nxt >> 1);
      // DEPTH is a power of two, so pointer increments wrap on their own.
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        o_ex_valid   <= 1'b1;
        o_ex_instr   <= head.instr;
        o_ex_operand <= head_operand;
      end else if (state == OUT && i_ex_ready) begin
        o_ex_valid <= 1'b0;
      end
      if (i_wb_done && state != WAIT_WB) o_wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_issue_serializer.sv
// Scoreboard bench for csr_issue_serializer: stimulus pushes expected dispatches,
// a monitor pops and compares them; an ex/wb responder closes the loop.
`timescale 1ns/1ps
module tb_csr_issue_serializer;

  localparam int INSTR_W = 113;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 16;
  localparam int DEP_W   = 4;
  localparam int REG_W   = 5;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [DEP_W-1:0] BYP_TAG  = 4'b1111;
  localparam logic [XLEN-1:0]  BYP_DATA = 32'hDEAD_BEEF;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               i_flush = 1'b0;
  logic               i_in_valid = 1'b0;
  logic               o_in_ready;
  logic [INSTR_W-1:0] i_in_instr = '0;
  logic               i_in_imm_sel = 1'b0;
  logic [XLEN-1:0]    i_in_imm = '0;
  logic [DEP_W-1:0]   i_in_dep = '0;
  logic [REG_W-1:0]   i_in_rs1 = '0;
  logic [REG_W-1:0]   o_rf_rs1;
  logic [XLEN-1:0]    i_rf_data;
  logic               i_byp_valid;
  logic [XLEN-1:0]    i_byp_data;
  logic               o_ex_valid;
  logic               i_ex_ready = 1'b0;
  logic [INSTR_W-1:0] o_ex_instr;
  logic [XLEN-1:0]    o_ex_operand;
  logic               i_wb_done = 1'b0;
  logic [CNT_W-1:0]   o_count, o_count_gray;
  logic               o_busy, o_wb_err;

  csr_issue_serializer dut (
    .clk(clk), .rstn(rstn), .i_flush(i_flush),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_instr(i_in_instr),
    .i_in_imm_sel(i_in_imm_sel), .i_in_imm(i_in_imm), .i_in_dep(i_in_dep),
    .i_in_rs1(i_in_rs1), .o_rf_rs1(o_rf_rs1), .i_rf_data(i_rf_data),
    .i_byp_valid(i_byp_valid), .i_byp_data(i_byp_data),
    .o_ex_valid(o_ex_valid), .i_ex_ready(i_ex_ready), .o_ex_instr(o_ex_instr),
    .o_ex_operand(o_ex_operand), .i_wb_done(i_wb_done),
    .o_count(o_count), .o_count_gray(o_count_gray), .o_busy(o_busy), .o_wb_err(o_wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    operand;
  } exp_t;

  exp_t            sb[$];
  int              rise_cyc[$];
  int              n_tests = 0, n_fail = 0;
  int              ex_ready_pct = 100, wb_lat_min = 0, wb_lat_max = 0;
  int              wb_req = 0, wb_issued = 0, byp_mode = 0, cyc = 0;
  bit              wb_enable = 1'b1, byp_rand = 1'b0;
  logic [XLEN-1:0] grf [32];

  // Environment: GRF model and bypass network (mode 0 random, 1 never valid, 2 always valid).
  assign i_rf_data   = grf[o_rf_rs1];
  assign i_byp_data  = BYP_DATA;
  assign i_byp_valid = (byp_mode == 2) || (byp_mode == 0 && byp_rand);

  initial forever begin
    @(negedge clk);
    byp_rand = ($urandom_range(1) == 1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_operand(input logic sel, input logic [XLEN-1:0] imm,
                                                  input logic [DEP_W-1:0] dep,
                                                  input logic [REG_W-1:0] rs1);
    if (sel) return imm;
    if (dep == BYP_TAG) return BYP_DATA;
    return grf[rs1];
  endfunction

  // Execute/writeback responder: random ready, writeback pulse a set latency after the handshake.
  initial begin : responder
    bit pending;
    int wait_cnt;
    int req_seen;
    pending = 0; wait_cnt = 0; req_seen = 0;
    forever begin
      @(negedge clk);
      i_wb_done = 1'b0;
      if (!rstn) pending = 0;
      if (wb_req != req_seen) begin
        req_seen  = wb_req;
        i_wb_done = 1'b1;
      end else if (pending) begin
        if (wait_cnt > 0) wait_cnt--;
        else if (wb_enable) begin
          i_wb_done = 1'b1;
          pending   = 0;
          wb_issued++;
        end
      end
      i_ex_ready = (int'($urandom_range(99)) < ex_ready_pct);
      if (rstn && o_ex_valid && i_ex_ready) begin
        pending  = 1;
        wait_cnt = int'($urandom_range(wb_lat_max, wb_lat_min));
      end
    end
  end

  // Monitor: pops the scoreboard on each new dispatch and checks hold/serialization rules.
  initial begin : monitor
    bit                 prev_valid;
    bit                 armed;
    int                 snap;
    exp_t               e;
    logic [INSTR_W-1:0] hold_instr;
    logic [XLEN-1:0]    hold_op;
    prev_valid = 0; armed = 0; snap = 0; hold_instr = '0; hold_op = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rstn) begin
        prev_valid = 0;
        armed      = 0;
        continue;
      end
      if (prev_valid && i_ex_ready) begin
        check("valid_drop_after_handshake", o_ex_valid, 1'b0);
      end else if (o_ex_valid && !prev_valid) begin
        rise_cyc.push_back(cyc);
        if (armed) check("dispatch_after_wb", wb_issued > snap, 1'b1);
        armed = 1;
        snap  = wb_issued;
        check("dispatch_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ex_instr", o_ex_instr, e.instr);
          check("ex_operand", o_ex_operand, e.operand);
        end
        hold_instr = o_ex_instr;
        hold_op    = o_ex_operand;
      end else if (o_ex_valid) begin
        check("hold_instr", o_ex_instr, hold_instr);
        check("hold_operand", o_ex_operand, hold_op);
      end
      prev_valid = o_ex_valid;
    end
  end

  // Offer one instruction for one cycle; acceptance follows the model's occupancy.
  task automatic enq(input logic [INSTR_W-1:0] instr, input logic sel, input logic [XLEN-1:0] imm,
                     input logic [DEP_W-1:0] dep, input logic [REG_W-1:0] rs1);
    bit acc;
    int n;
    n   = sb.size();
    acc = (n < DEPTH);
    check("in_ready", o_in_ready, acc);
    check("count", o_count, n);
    check("count_gray", o_count_gray, n ^ (n >> 1));
    i_in_valid = 1'b1; i_in_instr = instr; i_in_imm_sel = sel;
    i_in_imm = imm; i_in_dep = dep; i_in_rs1 = rs1;
    if (acc) sb.push_back('{instr: instr, operand: exp_operand(sel, imm, dep, rs1)});
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  task automatic enq_rand(input int imm_pct);
    logic [127:0]     w;
    logic [DEP_W-1:0] d;
    w = {$urandom, $urandom, $urandom, $urandom};
    d = ($urandom_range(3) == 0) ? BYP_TAG : DEP_W'($urandom_range(14));
    enq(w[INSTR_W-1:0], int'($urandom_range(99)) < imm_pct, $urandom, d, REG_W'($urandom));
  endtask

  task automatic flush(input bit with_enq);
    i_flush    = 1'b1;
    i_in_valid = with_enq;
    i_in_instr = INSTR_W'({$urandom, $urandom});
    sb.delete();
    @(negedge clk);
    i_flush    = 1'b0;
    i_in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", n < budget, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int i = 0; i < 32; i++) grf[i] = $urandom;
    tick(3);
    rstn = 1'b1;
    check("rst_ex_valid", o_ex_valid, 1'b0);
    check("rst_ex_instr", o_ex_instr, '0);
    check("rst_ex_operand", o_ex_operand, '0);
    check("rst_count", o_count, 0);
    check("rst_count_gray", o_count_gray, 0);
    check("rst_in_ready", o_in_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_wb_err", o_wb_err, 1'b0);

    // Single instruction: dispatch two cycles after enqueue, then nothing until writeback.
    wb_enable = 0;
    enq(INSTR_W'(113'h1_0000_CAFE), 1'b1, 32'h1234, '0, '0);
    check("single_cycle1_valid", o_ex_valid, 1'b0);
    tick(1);
    check("single_cycle2_valid", o_ex_valid, 1'b1);
    check("single_cycle2_operand", o_ex_operand, 32'h1234);
    enq(INSTR_W'(113'h2_0000_0002), 1'b1, 32'h5678, '0, '0);
    for (int i = 0; i < 6; i++) begin
      check("single_no_second_dispatch", o_ex_valid, 1'b0);
      check("single_busy_wait_wb", o_busy, 1'b1);
      check("single_queued", o_count, sb.size());
      tick(1);
    end
    wb_enable = 1;
    drain(100);

    // Serialization of GRF-sourced instructions, writeback 4 cycles after each handshake.
    wb_lat_min = 3; wb_lat_max = 3;
    grf[7] = 32'hA5A5_0001;
    base = rise_cyc.size();
    for (int i = 0; i < 3; i++) enq(INSTR_W'(100 + i), 1'b0, '0, 4'd2, 5'd7);
    drain(200);
    check("ser_dispatches", rise_cyc.size() - base, 3);
    for (int i = 1; i < 3; i++)
      check("ser_spacing_ge6", (rise_cyc[base+i] - rise_cyc[base+i-1]) >= 6, 1'b1);
    check("ser_count_final", o_count, 0);

    // Bypass stall: head waits for bypass valid, dispatches the cycle after.
    wb_lat_min = 0; wb_lat_max = 2;
    byp_mode = 1;
    enq(INSTR_W'(113'hB), 1'b0, '0, BYP_TAG, 5'd3);
    for (int i = 0; i < 5; i++) begin
      check("byp_stall_no_valid", o_ex_valid, 1'b0);
      tick(1);
    end
    byp_mode = 2;
    tick(1);
    check("byp_valid_rise", o_ex_valid, 1'b1);
    check("byp_operand", o_ex_operand, 32'hDEAD_BEEF);
    byp_mode = 0;
    drain(100);

    // Full and wrap: park one CSR in WAIT_WB, fill the queue past DEPTH, then drain.
    wb_enable = 0;
    enq_rand(100);
    tick(3);
    for (int i = 0; i < DEPTH + 1; i++) enq_rand(40);
    check("full_count", o_count, DEPTH);
    check("full_count_gray", o_count_gray, 5'b11000);
    check("full_in_ready", o_in_ready, 1'b0);
    wb_enable = 1;
    for (int i = 0; i < 4; i++) enq_rand(40);
    drain(400);

    // Backpressure: execute not ready for 7 cycles.
    ex_ready_pct = 0;
    enq_rand(100);
    enq_rand(100);
    for (int i = 0; i < 7; i++) begin
      check("bp_valid_held", o_ex_valid, 1'b1);
      check("bp_count_held", o_count, 1);
      tick(1);
    end
    ex_ready_pct = 100;
    drain(100);

    // Flush while waiting for writeback with 4 queued entries.
    wb_enable = 0;
    enq_rand(100);
    tick(3);
    for (int i = 0; i < 4; i++) enq_rand(100);
    check("flush_pre_count", o_count, 4);
    flush(1'b1);
    check("flush_count", o_count, 0);
    check("flush_count_gray", o_count_gray, 0);
    check("flush_state_kept", o_busy, 1'b1);
    wb_enable = 1;
    tick(4);
    check("flush_wb_idle", o_busy, 1'b0);
    check("flush_no_dispatch", o_ex_valid, 1'b0);

    // Flush suppresses a same-cycle IDLE dispatch.
    byp_mode = 1;
    enq(INSTR_W'(113'hF1), 1'b0, '0, BYP_TAG, 5'd1);
    byp_mode = 2;
    flush(1'b0);
    check("flush_supp_valid", o_ex_valid, 1'b0);
    check("flush_supp_count", o_count, 0);
    tick(1);
    check("flush_supp_valid_later", o_ex_valid, 1'b0);
    byp_mode = 0;

    // Stray writeback in IDLE sets the sticky error.
    check("wb_err_clean", o_wb_err, 1'b0);
    wb_req++;
    tick(3);
    check("wb_err_set", o_wb_err, 1'b1);
    tick(2);
    check("wb_err_sticky", o_wb_err, 1'b1);

    // Reset mid-OUT; a writeback during reset is not flagged.
    ex_ready_pct = 0;
    enq_rand(100);
    tick(1);
    check("rst_mid_setup_valid", o_ex_valid, 1'b1);
    rstn = 1'b0;
    sb.delete();
    wb_req++;
    tick(1);
    check("rst_mid_ex_valid", o_ex_valid, 1'b0);
    check("rst_mid_ex_instr", o_ex_instr, '0);
    check("rst_mid_ex_operand", o_ex_operand, '0);
    check("rst_mid_count", o_count, 0);
    check("rst_mid_count_gray", o_count_gray, 0);
    check("rst_mid_wb_err", o_wb_err, 1'b0);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_in_ready", o_in_ready, 1'b1);
    tick(1);
    rstn = 1'b1;
    ex_ready_pct = 100;
    tick(3);
    check("rst_wb_not_flagged", o_wb_err, 1'b0);
    check("rst_no_dispatch", o_ex_valid, 1'b0);

    // Randomized traffic with occasional flushes.
    ex_ready_pct = 70; wb_lat_min = 0; wb_lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 3)       flush($urandom_range(1) == 1);
      else if (r < 60) enq_rand(40);
      else             tick(1);
    end
    drain(3000);
    check("rand_final_count", o_count, 0);
    check("rand_final_wb_err", o_wb_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
